// File: rtl/timer_apb_slave.sv
// APB3 register front-end for the timer core: TDR/TCR/TSR/TIER plus read-only TCNT,
// with a fixed number of wait states per access and overflow/underflow status capture.
//
// state    | meaning
// ST_IDLE  | no transfer in progress (also the bus setup cycle)
// ST_WAIT  | access phase, pready=0 while wcnt < WAIT_STATES
// ST_READY | access phase, pready=1 for this single cycle; write commits on its closing edge
module timer_apb_slave #(
   parameter int WAIT_STATES = 0
) (
   input  logic       pclk,
   input  logic       preset,
   input  logic       psel,
   input  logic       penable,
   input  logic       pwrite,
   input  logic [7:0] paddr,
   input  logic [7:0] pwdata,
   output logic [7:0] prdata,
   output logic       pready,
   output logic       pslverr,
   output logic [7:0] tdr_o,
   output logic [1:0] cks_o,
   output logic       en_o,
   output logic       dn_o,
   output logic       load_o,
   input  logic [7:0] cnt_i,
   input  logic       ovf_set_i,
   input  logic       udf_set_i,
   output logic       irq_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_READY} state_t;

   localparam logic [3:0] WS = 4'(WAIT_STATES);

   state_t     state, state_nxt;
   logic [3:0] wcnt, wcnt_nxt;

   logic [7:0] tdr;
   logic [1:0] cks;
   logic       en, dn;
   logic [1:0] tsr, tier;
   logic [7:0] prdata_q;
   logic       err_q, load_q;

   logic       setup_hit, addr_err, commit;
   logic [1:0] w1c;
   logic [7:0] rd_mux;

   assign setup_hit = (state == ST_IDLE) && psel && !penable;
   assign addr_err  = (paddr > 8'h04) || (pwrite && paddr == 8'h04);
   assign commit    = (state == ST_READY) && psel && penable && pwrite && !addr_err;
   assign w1c       = (commit && paddr == 8'h02) ? pwdata[1:0] : 2'b00;

   always_comb begin
      rd_mux = 8'h00;
      case (paddr)
         8'h00:   rd_mux = tdr;
         8'h01:   rd_mux = {2'b00, dn, en, 2'b00, cks};
         8'h02:   rd_mux = {6'b0, tsr};
         8'h03:   rd_mux = {6'b0, tier};
         8'h04:   rd_mux = cnt_i;
         default: rd_mux = 8'h00;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         state <= ST_IDLE;
         wcnt  <= 4'd0;
      end else begin
         state <= state_nxt;
         wcnt  <= wcnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      wcnt_nxt  = wcnt;
      case (state)
         ST_IDLE: begin
            if (psel && !penable) begin
               wcnt_nxt  = 4'd0;
               state_nxt = (WS == 4'd0) ? ST_READY : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!psel) begin
               // master dropped psel mid-access: abandon the transfer
               state_nxt = ST_IDLE;
               wcnt_nxt  = 4'd0;
            end else begin
               wcnt_nxt = wcnt + 4'd1;
               if (wcnt_nxt == WS) state_nxt = ST_READY;
            end
         end
         ST_READY: begin
            state_nxt = ST_IDLE;
            wcnt_nxt  = 4'd0;
         end
         default: begin
            state_nxt = ST_IDLE;
            wcnt_nxt  = 4'd0;
         end
      endcase
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         tdr      <= 8'h00;
         cks      <= 2'b00;
         en       <= 1'b0;
         dn       <= 1'b0;
         tsr      <= 2'b00;
         tier     <= 2'b00;
         prdata_q <= 8'h00;
         err_q    <= 1'b0;
         load_q   <= 1'b0;
      end else begin
         load_q <= commit && (paddr == 8'h01) && pwdata[7];
         // read data is captured at setup and held for the whole access phase
         if (setup_hit) begin
            prdata_q <= (pwrite || addr_err) ? 8'h00 : rd_mux;
            err_q    <= addr_err;
         end else if (state_nxt == ST_IDLE) begin
            prdata_q <= 8'h00;
            err_q    <= 1'b0;
         end
         if (commit) begin
            case (paddr)
               8'h00: tdr <= pwdata;
               8'h01: begin
                  dn  <= pwdata[5];
                  en  <= pwdata[4];
                  cks <= pwdata[1:0];
               end
               8'h03: tier <= pwdata[1:0];
               default: ;
            endcase
         end
         tsr <= {udf_set_i, ovf_set_i} | (tsr & ~w1c);
      end
   end

   assign pready  = (state == ST_READY);
   assign pslverr = pready && err_q;
   assign prdata  = prdata_q;
   assign tdr_o   = tdr;
   assign cks_o   = cks;
   assign en_o    = en;
   assign dn_o    = dn;
   assign load_o  = load_q;
   assign irq_o   = (tsr[0] & tier[0]) | (tsr[1] & tier[1]);

endmodule

// File: tb/tb_timer_apb_slave.sv
// Scoreboard bench for timer_apb_slave with seven wait states per access.
module tb_timer_apb_slave;

   localparam int WS = 7;

   logic       pclk = 1'b0;
   logic       preset = 1'b1;
   logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [7:0] paddr = 8'h00, pwdata = 8'h00;
   logic [7:0] prdata;
   logic       pready, pslverr;
   logic [7:0] tdr_o;
   logic [1:0] cks_o;
   logic       en_o, dn_o, load_o, irq_o;
   logic [7:0] cnt_i = 8'h00;
   logic       ovf_set_i = 1'b0, udf_set_i = 1'b0;

   int checks = 0;
   int failures = 0;

   typedef struct {
      string      tag;
      logic [7:0] rdata;
      logic       err;
   } exp_t;
   exp_t sb[$];

   timer_apb_slave #(.WAIT_STATES(WS)) dut (
      .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
      .tdr_o(tdr_o), .cks_o(cks_o), .en_o(en_o), .dn_o(dn_o), .load_o(load_o),
      .cnt_i(cnt_i), .ovf_set_i(ovf_set_i), .udf_set_i(udf_set_i), .irq_o(irq_o)
   );

   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic apb_xfer(input string tag, input logic wr, input logic [7:0] addr,
                           input logic [7:0] data, input logic [7:0] exp_rd,
                           input logic exp_err, input logic ovf_at_commit);
      int   waits;
      exp_t e;
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
      sb.push_back('{tag: tag, rdata: exp_rd, err: exp_err});
      @(posedge pclk); #1;
      penable = 1'b1;
      waits = 0;
      while (!pready && waits < 50) begin
         @(posedge pclk); #1;
         waits++;
      end
      e = sb.pop_front();
      if (!pready) begin
         chk({e.tag, "_timeout"}, 32'(waits), 32'(WS));
      end else begin
         chk({e.tag, "_waits"}, 32'(waits), 32'(WS));
         chk({e.tag, "_prdata"}, 32'(prdata), 32'(e.rdata));
         chk({e.tag, "_pslverr"}, 32'(pslverr), 32'(e.err));
      end
      if (ovf_at_commit) ovf_set_i = 1'b1;
      @(posedge pclk); #1;
      ovf_set_i = 1'b0;
      psel = 1'b0; penable = 1'b0;
   endtask

   initial begin
      logic seen;

      repeat (3) @(posedge pclk);
      #1;
      chk("rst_prdata", 32'(prdata), 0);
      chk("rst_pready", 32'(pready), 0);
      chk("rst_pslverr", 32'(pslverr), 0);
      chk("rst_load", 32'(load_o), 0);
      chk("rst_tdr", 32'(tdr_o), 0);
      chk("rst_irq", 32'(irq_o), 0);
      preset = 1'b0;

      apb_xfer("wr_tcr3", 1'b1, 8'h01, 8'h03, 8'h00, 1'b0, 1'b0);
      chk("cks", 32'(cks_o), 32'h3);
      apb_xfer("rd_tcr3", 1'b0, 8'h01, 8'h00, 8'h03, 1'b0, 1'b0);

      apb_xfer("wr_tcr90", 1'b1, 8'h01, 8'h90, 8'h00, 1'b0, 1'b0);
      chk("load_pulse", 32'(load_o), 1);
      chk("en", 32'(en_o), 1);
      chk("dn", 32'(dn_o), 0);
      @(posedge pclk); #1;
      chk("load_single", 32'(load_o), 0);
      apb_xfer("rd_tcr10", 1'b0, 8'h01, 8'h00, 8'h10, 1'b0, 1'b0);
      chk("load_no_read_pulse", 32'(load_o), 0);

      apb_xfer("wr_tier", 1'b1, 8'h03, 8'h01, 8'h00, 1'b0, 1'b0);
      chk("irq_idle", 32'(irq_o), 0);
      @(posedge pclk); #1; ovf_set_i = 1'b1;
      @(posedge pclk); #1; ovf_set_i = 1'b0;
      chk("irq_ovf", 32'(irq_o), 1);
      apb_xfer("rd_tsr_ovf", 1'b0, 8'h02, 8'h00, 8'h01, 1'b0, 1'b0);
      apb_xfer("w1c_vs_set", 1'b1, 8'h02, 8'h01, 8'h00, 1'b0, 1'b1);
      chk("irq_set_wins", 32'(irq_o), 1);
      apb_xfer("rd_tsr_kept", 1'b0, 8'h02, 8'h00, 8'h01, 1'b0, 1'b0);
      apb_xfer("w1c_ovf", 1'b1, 8'h02, 8'h01, 8'h00, 1'b0, 1'b0);
      chk("irq_cleared", 32'(irq_o), 0);
      apb_xfer("rd_tsr_clr", 1'b0, 8'h02, 8'h00, 8'h00, 1'b0, 1'b0);

      @(posedge pclk); #1; udf_set_i = 1'b1;
      @(posedge pclk); #1; udf_set_i = 1'b0;
      chk("irq_udf_masked", 32'(irq_o), 0);
      apb_xfer("rd_tsr_udf", 1'b0, 8'h02, 8'h00, 8'h02, 1'b0, 1'b0);
      apb_xfer("w1c_udf", 1'b1, 8'h02, 8'h02, 8'h00, 1'b0, 1'b0);
      apb_xfer("rd_tsr_clr2", 1'b0, 8'h02, 8'h00, 8'h00, 1'b0, 1'b0);

      apb_xfer("wr_tdr", 1'b1, 8'h00, 8'h3C, 8'h00, 1'b0, 1'b0);
      chk("tdr", 32'(tdr_o), 32'h3C);
      cnt_i = 8'hA5;
      apb_xfer("rd_tcnt", 1'b0, 8'h04, 8'h00, 8'hA5, 1'b0, 1'b0);
      apb_xfer("wr_tcnt", 1'b1, 8'h04, 8'h12, 8'h00, 1'b1, 1'b0);
      chk("tdr_after_tcnt_wr", 32'(tdr_o), 32'h3C);
      apb_xfer("rd_bad", 1'b0, 8'h07, 8'h00, 8'h00, 1'b1, 1'b0);
      apb_xfer("wr_bad", 1'b1, 8'h07, 8'hFF, 8'h00, 1'b1, 1'b0);
      chk("tdr_after_bad_wr", 32'(tdr_o), 32'h3C);
      apb_xfer("rd_tcr_after_bad", 1'b0, 8'h01, 8'h00, 8'h10, 1'b0, 1'b0);
      chk("pslverr_idle", 32'(pslverr), 0);

      // reset in the middle of a TDR write must discard it
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h55;
      @(posedge pclk); #1;
      penable = 1'b1;
      seen = pready;
      repeat (3) begin
         @(posedge pclk); #1;
         seen |= pready;
      end
      preset = 1'b1;
      @(posedge pclk); #1;
      preset = 1'b0;
      chk("rst_mid_pready", 32'(pready), 0);
      repeat (10) begin
         @(posedge pclk); #1;
         seen |= pready;
      end
      psel = 1'b0; penable = 1'b0;
      @(posedge pclk); #1;
      chk("rst_mid_never_ready", 32'(seen), 0);
      chk("rst_mid_tdr", 32'(tdr_o), 0);
      chk("rst_mid_en", 32'(en_o), 0);
      apb_xfer("rd_tdr_post_rst", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

      chk("sb_empty", 32'(sb.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
